dmem_mmio: RTL and testbench
============================

// Module: dmem_mmio
// PURPOSE
//   Data-side memory responder for the single-cycle ARM core. It serves the
//   core's MemWrite / ALUResult (address) / WriteData / ReadData bus.
//   Word RAM, plus an MMIO window: LED register, synchronised switches,
//   free-running cycle counter, and a byte TX FIFO drained by a valid/ready sink.
//   ReadData is combinational, so the core still completes loads in one cycle.
// PARAMETERS
//   RAM_WORDS   64            RAM depth in 32-bit words (power of 2)
//   MMIO_BASE   32'h0000_1000 base byte address of the MMIO window
//   FIFO_DEPTH  4             TX FIFO entries (power of 2, >=2)
//   LED_W       8             LED register width
//   SW_W        8             switch input width
// PORTS
//   clk        in   1      core clock
//   reset      in   1      asynchronous, active-high reset
//   MemWrite   in   1      write strobe from core (one store per cycle)
//   ALUResult  in   32     byte address; a[1:0] ignored (word access only)
//   WriteData  in   32     store data
//   ReadData   out  32     load data, combinational from address + state
//   sw         in   SW_W   asynchronous switch inputs
//   led        out  LED_W  LED register
//   tx_data    out  8      FIFO head byte
//   tx_valid   out  1      FIFO non-empty
//   tx_ready   in   1      sink accepts head when tx_valid & tx_ready
// BEHAVIOUR
//   Decode (word index w = a[31:2]):
//     RAM : a < RAM_WORDS*4, index a[log2(RAM_WORDS)+1:2].
//     +0x00 LED RW | +0x04 SW RO | +0x08 CYCLE RO, write clears
//     +0x0C TXDATA WO, reads 0 | +0x10 STATUS RO, write bit8=1 clears OVF.
//     Any other address: read 0, write ignored.
//   Reset (async): led=0, cycle=0, FIFO empty (tx_valid=0, tx_data=0),
//     OVF=0, sw sync flops=0. RAM contents are NOT reset.
//   RAM: write on rising clk when MemWrite & RAM hit. Read is async.
//     A same-cycle read at the written address returns the OLD word.
//   LED: led <= WriteData[LED_W-1:0] on write. Read is zero-extended.
//   SW: 2-flop synchroniser. Reads return the 2nd stage, zero-extended,
//     2-3 cycles after an input change.
//   CYCLE: +1 every cycle, wraps 32'hFFFF_FFFF -> 0.
//     A write forces 0 at that edge (increment suppressed). The next read is 0.
//   STATUS: bit0 full, bit1 empty, bits[6:4] count (0..FIFO_DEPTH),
//     bit8 OVF (sticky), all other bits 0.
//   TX FIFO: circular buffer with rd/wr pointers and a count.
//     Push = MemWrite & TXDATA hit, data WriteData[7:0].
//     Pop = tx_valid & tx_ready. tx_data = mem[rd_ptr].
//     Push & ~full: accepted. Push & full & ~pop: dropped, OVF <= 1.
//     Push & full & pop: both occur, count unchanged, no OVF.
//     Push & empty: tx_valid rises next cycle (no bypass).
//     Pointers wrap modulo FIFO_DEPTH.
//     The OVF clear write and an overflow in the same cycle cannot coincide
//     (different addresses, one store per cycle).
//   Reset mid-transfer: the FIFO empties immediately, tx_valid drops
//     asynchronously, and queued bytes are lost.
//   Latency: store effects are visible to loads in the next cycle. Loads take 0 cycles.
// TESTING
//   1 RAM: store 0xDEADBEEF @0x10, load @0x10 next cycle -> 0xDEADBEEF;
//     load @0x13 -> the same word.
//   2 LED/unmapped: store 0x1A5 @BASE -> led=0xA5, load @BASE=0xA5;
//     load @BASE+0x40 -> 0, store there changes nothing.
//   3 FIFO fill: tx_ready=0, push 0x11..0x15 -> count=4, full=1, OVF=1;
//     drain -> tx_data 0x11,0x12,0x13,0x14 only.
//   4 Full + simultaneous push/pop: FIFO full, tx_ready=1, push 0x77 ->
//     count stays 4, OVF stays 0, 0x77 emitted last.
//   5 CYCLE: store @BASE+8, load after 5 idle cycles -> 5;
//     preload 0xFFFFFFFF via a force -> wraps to 0 next cycle.
//   6 Reset mid-drain: assert reset with 3 queued bytes -> tx_valid=0,
//     led=0, STATUS=0x2 immediately; RAM word from test 1 still 0xDEADBEEF.

Source files
------------

// File: rtl/dmem_mmio.sv
// rtl/dmem_mmio.sv - data-side memory responder: word RAM plus LED/SW/CYCLE/TX-FIFO MMIO window
// Loads are combinational so the core still completes them in one cycle; stores land on the rising edge.
module dmem_mmio #(
  parameter int unsigned RAM_WORDS  = 64,
  parameter logic [31:0] MMIO_BASE  = 32'h0000_1000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LED_W      = 8,
  parameter int unsigned SW_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [31:0]       ALUResult,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  led,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [29:0] LP_BASE_W = MMIO_BASE[31:2];

  logic [31:0]      r_ram [RAM_WORDS];
  logic [7:0]       r_fifo [FIFO_DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic [LED_W-1:0] r_led;
  logic [SW_W-1:0]  r_sw_s1;
  logic [SW_W-1:0]  r_sw_s2;
  logic [31:0]      r_cycle;

  logic [29:0] w_word;
  logic        w_ram_hit;
  logic        w_led_hit;
  logic        w_sw_hit;
  logic        w_cyc_hit;
  logic        w_txd_hit;
  logic        w_sts_hit;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_push_ok;
  logic [31:0] w_status;

  // RAM decode takes priority should the MMIO window ever be placed inside the RAM range
  assign w_word    = ALUResult[31:2];
  assign w_ram_hit = (ALUResult < 32'(RAM_WORDS * 4));
  assign w_led_hit = ~w_ram_hit & (w_word == LP_BASE_W);
  assign w_sw_hit  = ~w_ram_hit & (w_word == LP_BASE_W + 30'd1);
  assign w_cyc_hit = ~w_ram_hit & (w_word == LP_BASE_W + 30'd2);
  assign w_txd_hit = ~w_ram_hit & (w_word == LP_BASE_W + 30'd3);
  assign w_sts_hit = ~w_ram_hit & (w_word == LP_BASE_W + 30'd4);

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_push    = MemWrite & w_txd_hit;
  assign w_pop     = ~w_empty & tx_ready;
  assign w_push_ok = w_push & (~w_full | w_pop);

  assign tx_valid  = ~w_empty;
  assign tx_data   = w_empty ? 8'd0 : r_fifo[r_rd_ptr];
  assign led       = r_led;
  assign w_status  = {23'd0, r_ovf, 1'b0, 3'(r_count), 2'b00, w_empty, w_full};

  always_comb begin
    ReadData = 32'd0;
    if (w_ram_hit)      ReadData = r_ram[ALUResult[AW+1:2]];
    else if (w_led_hit) ReadData = 32'(r_led);
    else if (w_sw_hit)  ReadData = 32'(r_sw_s2);
    else if (w_cyc_hit) ReadData = r_cycle;
    else if (w_sts_hit) ReadData = w_status;
  end

  // Storage arrays carry no reset so they map onto plain RAM
  always_ff @(posedge clk) begin
    if (MemWrite & w_ram_hit) r_ram[ALUResult[AW+1:2]] <= WriteData;
    if (w_push_ok)            r_fifo[r_wr_ptr] <= WriteData[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led   <= '0;
      r_sw_s1 <= '0;
      r_sw_s2 <= '0;
      r_cycle <= 32'd0;
    end else begin
      r_sw_s1 <= sw;
      r_sw_s2 <= r_sw_s1;
      if (MemWrite & w_led_hit) r_led <= WriteData[LED_W-1:0];
      if (MemWrite & w_cyc_hit) r_cycle <= 32'd0;
      else                      r_cycle <= r_cycle + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
      if (w_push & ~w_push_ok)                     r_ovf <= 1'b1;
      else if (MemWrite & w_sts_hit & WriteData[8]) r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb/tb_dmem_mmio.sv - scoreboard bench for dmem_mmio
// Expected TX bytes are queued as pushes are driven and popped when the sink accepts.
module tb_dmem_mmio;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] A_LED = BASE + 32'h00;
  localparam logic [31:0] A_SW  = BASE + 32'h04;
  localparam logic [31:0] A_CYC = BASE + 32'h08;
  localparam logic [31:0] A_TXD = BASE + 32'h0C;
  localparam logic [31:0] A_STS = BASE + 32'h10;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [7:0]  sw;
  logic [7:0]  led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic       m_ovf;

  dmem_mmio dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .ReadData(ReadData), .sw(sw), .led(led),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change only at posedge+1, so negedge sees the values that the next edge will use
  always @(negedge clk) begin
    if (!reset && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) chk("tx_unexpected", {24'd0, tx_data}, 32'hFFFF_FFFF);
      else chk("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    if (a == A_TXD) begin
      if (exp_q.size() < DEPTH || tx_ready) exp_q.push_back(d[7:0]);
      else m_ovf = 1'b1;
    end
    if (a == A_STS && d[8]) m_ovf = 1'b0;
    MemWrite = 1'b1; ALUResult = a; WriteData = d;
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [31:0] exp);
    ALUResult = a;
    #1;
    chk(tag, ReadData, exp);
  endtask

  function automatic logic [31:0] status_exp();
    int c = exp_q.size();
    return {23'd0, m_ovf, 1'b0, 3'(c), 2'b00, (c == 0), (c == DEPTH)};
  endfunction

  task automatic drain(input string tag);
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    idle(1);
    chk({tag, "_valid_low"}, {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; ALUResult = 32'd0; WriteData = 32'd0;
    sw = 8'd0; tx_ready = 1'b0; m_ovf = 1'b0;
    idle(2);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_led", {24'd0, led}, 32'd0);
    load("rst_status", A_STS, 32'h2);
    reset = 1'b0;
    idle(1);

    // RAM, including old-data-on-same-cycle-read
    store(32'h20, 32'h0000_000A);
    MemWrite = 1'b1; ALUResult = 32'h20; WriteData = 32'h1234_5678;
    #1;
    chk("ram_old_word", ReadData, 32'h0000_000A);
    @(posedge clk); #1; MemWrite = 1'b0;
    load("ram_new_word", 32'h20, 32'h1234_5678);
    store(32'h10, 32'hDEAD_BEEF);
    load("ram_0x10", 32'h10, 32'hDEAD_BEEF);
    load("ram_0x13", 32'h13, 32'hDEAD_BEEF);

    // LED, unmapped, TXDATA reads
    store(A_LED, 32'h0000_01A5);
    chk("led_pin", {24'd0, led}, 32'hA5);
    load("led_read", A_LED, 32'hA5);
    load("unmapped_read", BASE + 32'h40, 32'd0);
    store(BASE + 32'h40, 32'hFFFF_FFFF);
    load("unmapped_after", BASE + 32'h40, 32'd0);
    chk("led_unchanged", {24'd0, led}, 32'hA5);
    load("txdata_read", A_TXD, 32'd0);

    // switch synchroniser
    sw = 8'h3C;
    idle(1);
    load("sw_1cyc", A_SW, 32'd0);
    idle(1);
    load("sw_2cyc", A_SW, 32'h3C);

    // FIFO fill with overflow
    for (int i = 0; i < 5; i++) store(A_TXD, 32'h11 + i);
    load("fill_status", A_STS, status_exp());
    chk("fill_status_const", ReadData, 32'h0000_0141);
    drain("fill");
    load("empty_status", A_STS, status_exp());

    // full with simultaneous push and pop
    store(A_STS, 32'h100);
    load("ovf_cleared", A_STS, 32'h2);
    for (int i = 0; i < 4; i++) store(A_TXD, 32'h21 + i);
    tx_ready = 1'b1;
    store(A_TXD, 32'h77);
    load("pushpop_status", A_STS, 32'h0000_0041);
    chk("pushpop_model", ReadData, status_exp());
    drain("pushpop");

    // cycle counter
    store(A_CYC, 32'h0);
    load("cyc_cleared", A_CYC, 32'd0);
    idle(5);
    load("cyc_5", A_CYC, 32'd5);
    @(negedge clk);
    force dut.r_cycle = 32'hFFFF_FFFF;
    #1;
    release dut.r_cycle;
    #1;
    chk("cyc_preload", ReadData, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("cyc_wrap", ReadData, 32'd0);

    // reset while bytes are queued
    for (int i = 0; i < 3; i++) store(A_TXD, 32'h51 + i);
    chk("pre_reset_valid", {31'd0, tx_valid}, 32'd1);
    reset = 1'b1;
    exp_q.delete();
    m_ovf = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_mid_led", {24'd0, led}, 32'd0);
    load("rst_mid_status", A_STS, 32'h2);
    idle(2);
    reset = 1'b0;
    idle(1);
    load("ram_survives", 32'h10, 32'hDEAD_BEEF);
    chk("post_rst_valid", {31'd0, tx_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
